// File: rtl/trim_sweep_pkg.sv
// State encoding shared by the trim sweep generator.
// Encodings are plain constants so legacy tools can use them; the enum wraps them for RTL use.
package trim_sweep_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_LOAD  = S_LOAD,
      ST_SHIFT = S_SHIFT,
      ST_GAP   = S_GAP
   } state_e;

endpackage

// File: rtl/trim_clk_div.sv
// Half-period divider: tick on the last cycle of each half period, phase 0 = first half, 1 = second half.
// phase_nxt exposes the value phase takes after the coming edge so the caller can register ENCLK.
module trim_clk_div #(
   parameter int HALF_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic phase,
   output logic phase_nxt
);

   localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   assign tick      = (cnt_q == CNT_MAX);
   assign phase     = phase_q;
   assign phase_nxt = phase_d;

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      if (clr) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (tick) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/trim_sweep_gen.sv
// Trim-code sweep generator: shifts CODE_START..CODE_END out as framed words on ENCLK/DOUT.
// Define TRIM_SWEEP_PARITY_EN to append an even-parity bit to every frame.
module trim_sweep_gen
   import trim_sweep_pkg::*;
#(
   parameter int CODE_W    = 12,
   parameter int HALF_DIV  = 25000000,
   parameter int GAP_BITS  = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic              CLK50,
   input  logic              RST,
   input  logic              START,
   input  logic              STOP,
   input  logic              CONT,
   input  logic [CODE_W-1:0] CODE_START,
   input  logic [CODE_W-1:0] CODE_END,
   output logic              ENCLK,
   output logic              DOUT,
   output logic [CODE_W-1:0] TRIMCODE,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic              SWEEP_DONE
);

`ifdef TRIM_SWEEP_PARITY_EN
   localparam int FRAME_W = CODE_W + 1;
`else
   localparam int FRAME_W = CODE_W;
`endif
   localparam logic [31:0] LAST_BIT = 32'(FRAME_W - 1);
   localparam logic [31:0] LAST_GAP = 32'(GAP_BITS - 1);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d, start_q, start_d, end_q, end_d, trim_q, trim_d;
   logic                cont_q, cont_d;
   logic [FRAME_W-1:0]  sreg_q, sreg_d, frame;
   logic [31:0]         bit_cnt_q, bit_cnt_d;
   logic                dout_q, dout_d, enclk_q, enclk_d;
   logic                div_clr, tick, phase, phase_nxt, bit_end;

   trim_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
      .clk       (CLK50),
      .rst       (RST),
      .clr       (div_clr),
      .tick      (tick),
      .phase     (phase),
      .phase_nxt (phase_nxt)
   );

   // Divider restarts from zero at every LOAD so each frame begins on a clean bit boundary.
   assign div_clr  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign bit_end  = tick && phase;
   assign ENCLK    = enclk_q;
   assign DOUT     = dout_q;
   assign TRIMCODE = trim_q;
   assign BUSY     = (state_q != ST_IDLE);

   // frame[i] is the i-th bit placed on the wire.
   always_comb begin
      frame = '0;
      for (int i = 0; i < CODE_W; i++)
         frame[i] = (MSB_FIRST != 0) ? code_q[CODE_W-1-i] : code_q[i];
`ifdef TRIM_SWEEP_PARITY_EN
      frame[CODE_W] = ^code_q;
`endif
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      start_d    = start_q;
      end_d      = end_q;
      cont_d     = cont_q;
      trim_d     = trim_q;
      sreg_d     = sreg_q;
      bit_cnt_d  = bit_cnt_q;
      dout_d     = dout_q;
      FRAME_DONE = 1'b0;
      SWEEP_DONE = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START && !STOP) begin
               start_d = CODE_START;
               end_d   = CODE_END;
               cont_d  = CONT;
               code_d  = CODE_START;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            trim_d    = code_q;
            sreg_d    = frame >> 1;
            dout_d    = frame[0];
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  FRAME_DONE = 1'b1;
                  dout_d     = 1'b0;
                  bit_cnt_d  = '0;
                  state_d    = ST_GAP;
               end else begin
                  dout_d    = sreg_q[0];
                  sreg_d    = sreg_q >> 1;
                  bit_cnt_d = bit_cnt_q + 32'd1;
               end
            end
         end
         ST_GAP: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_GAP) begin
                  bit_cnt_d = '0;
                  state_d   = ST_LOAD;
                  if (code_q != end_q) begin
                     code_d = code_q + CODE_W'(1);
                  end else if (cont_q) begin
                     code_d = start_q;
                  end else begin
                     SWEEP_DONE = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // An abort wins over everything, including a completion pulse due this cycle.
      if (STOP && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         dout_d     = 1'b0;
         bit_cnt_d  = '0;
         FRAME_DONE = 1'b0;
         SWEEP_DONE = 1'b0;
      end
      enclk_d = (state_d == ST_SHIFT) && phase_nxt;
   end

   always_ff @(posedge CLK50) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         trim_q    <= '0;
         bit_cnt_q <= '0;
         dout_q    <= 1'b0;
         enclk_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         trim_q    <= trim_d;
         bit_cnt_q <= bit_cnt_d;
         dout_q    <= dout_d;
         enclk_q   <= enclk_d;
      end
      code_q  <= code_d;
      start_q <= start_d;
      end_q   <= end_d;
      cont_q  <= cont_d;
      sreg_q  <= sreg_d;
   end

endmodule

// File: tb/tb_trim_sweep_gen.sv
// Directed bench for trim_sweep_gen (CODE_W=4, HALF_DIV=2, GAP_BITS=1); a second LSB-first instance shares inputs.
module tb_trim_sweep_gen;

   localparam int CW = 4;
`ifdef TRIM_SWEEP_PARITY_EN
   localparam int FW = 5;
`else
   localparam int FW = 4;
`endif

   logic       clk = 1'b0;
   logic       rst, start, stop, cont;
   logic [3:0] cs, ce;
   logic       enclk, dout, busy, fdone, sdone;
   logic [3:0] trim;
   logic       enclk_l, dout_l, busy_l, fdone_l, sdone_l;
   logic [3:0] trim_l;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   trim_sweep_gen #(.CODE_W(CW), .HALF_DIV(2), .GAP_BITS(1), .MSB_FIRST(1)) dut (
      .CLK50(clk), .RST(rst), .START(start), .STOP(stop), .CONT(cont),
      .CODE_START(cs), .CODE_END(ce), .ENCLK(enclk), .DOUT(dout), .TRIMCODE(trim),
      .BUSY(busy), .FRAME_DONE(fdone), .SWEEP_DONE(sdone)
   );

   trim_sweep_gen #(.CODE_W(CW), .HALF_DIV(2), .GAP_BITS(1), .MSB_FIRST(0)) dut_l (
      .CLK50(clk), .RST(rst), .START(start), .STOP(stop), .CONT(cont),
      .CODE_START(cs), .CODE_END(ce), .ENCLK(enclk_l), .DOUT(dout_l), .TRIMCODE(trim_l),
      .BUSY(busy_l), .FRAME_DONE(fdone_l), .SWEEP_DONE(sdone_l)
   );

   // Expected wire bit b of an MSB-first frame carrying code (parity after the data bits).
   function automatic logic exp_msb(input logic [3:0] code, input int b);
      if (b >= CW) return ^code;
      return code[CW-1-b];
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; cs = '0; ce = '0;
      repeat (3) @(negedge clk);
      checks++; if (enclk !== 1'b0) begin failures++; $display("FAIL reset_enclk actual=%b expected=0", enclk); end
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout actual=%b expected=0", dout); end
      checks++; if (trim !== 4'd0) begin failures++; $display("FAIL reset_trim actual=%0d expected=0", trim); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
      checks++; if (fdone !== 1'b0 || sdone !== 1'b0) begin failures++; $display("FAIL reset_pulses actual=%b%b expected=00", fdone, sdone); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy actual=%b expected=0", busy); end
   endtask

   task automatic test_sweep();
      logic [3:0] code;
      logic       e;
      int         fd, sd;
      fd = 0; sd = 0;
      cs = 4'd3; ce = 4'd5; cont = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if (busy !== 1'b1 || dout !== 1'b0 || enclk !== 1'b0) begin failures++; $display("FAIL sweep_load busy_dout_enclk actual=%b%b%b expected=100", busy, dout, enclk); end
      for (int f = 0; f < 3; f++) begin
         code = 4'(3 + f);
         for (int b = 0; b < FW; b++) begin
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               e = exp_msb(code, b);
               checks++; if (dout !== e) begin failures++; $display("FAIL sweep_dout f=%0d b=%0d c=%0d actual=%b expected=%b", f, b, c, dout, e); end
               e = (c >= 2);
               checks++; if (enclk !== e) begin failures++; $display("FAIL sweep_enclk f=%0d b=%0d c=%0d actual=%b expected=%b", f, b, c, enclk, e); end
               checks++; if (trim !== code) begin failures++; $display("FAIL sweep_trim f=%0d actual=%0d expected=%0d", f, trim, code); end
               e = (b == FW - 1) && (c == 3);
               checks++; if (fdone !== e) begin failures++; $display("FAIL sweep_fdone f=%0d b=%0d c=%0d actual=%b expected=%b", f, b, c, fdone, e); end
               if (fdone === 1'b1) fd++;
            end
         end
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (dout !== 1'b0 || enclk !== 1'b0 || busy !== 1'b1 || fdone !== 1'b0) begin failures++; $display("FAIL sweep_gap f=%0d c=%0d dout_enclk_busy_fdone actual=%b%b%b%b expected=0010", f, c, dout, enclk, busy, fdone); end
            e = (f == 2) && (c == 3);
            checks++; if (sdone !== e) begin failures++; $display("FAIL sweep_sdone f=%0d c=%0d actual=%b expected=%b", f, c, sdone, e); end
            if (sdone === 1'b1) sd++;
         end
         @(negedge clk);
         e = (f < 2);
         checks++; if (busy !== e) begin failures++; $display("FAIL sweep_after_gap f=%0d busy actual=%b expected=%b", f, busy, e); end
      end
      checks++; if (fd != 3 || sd != 1) begin failures++; $display("FAIL sweep_pulse_counts actual fd=%0d sd=%0d expected fd=3 sd=1", fd, sd); end
   endtask

   task automatic test_wrap();
      logic [3:0] seq[$];
      logic [3:0] exp_seq[4];
      logic [3:0] got;
      int         sd, n;
      exp_seq = '{4'd14, 4'd15, 4'd0, 4'd1};
      sd = 0; n = 0;
      cs = 4'd14; ce = 4'd1; cont = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk); n++;
         if (fdone === 1'b1) seq.push_back(trim);
         if (sdone === 1'b1) sd++;
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_timeout busy actual=%b expected=0", busy); end
      checks++; if (seq.size() != 4) begin failures++; $display("FAIL wrap_frames actual=%0d expected=4", seq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < seq.size()) ? seq[i] : 4'hx;
         checks++; if (got !== exp_seq[i]) begin failures++; $display("FAIL wrap_code[%0d] actual=%0d expected=%0d", i, got, exp_seq[i]); end
      end
      checks++; if (sd != 1) begin failures++; $display("FAIL wrap_sdone actual=%0d expected=1", sd); end
   endtask

   task automatic test_cont_stop();
      logic [3:0] seq[$];
      logic [3:0] got, exp_c;
      int         sd, n;
      bit         hit;
      sd = 0; n = 0; hit = 1'b0;
      cs = 4'd2; ce = 4'd3; cont = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0; cs = 4'd9; ce = 4'd9; cont = 1'b0;
      while (seq.size() < 4 && n < 200) begin
         @(negedge clk); n++;
         if (n == 30) start = 1'b1;
         if (n == 31) start = 1'b0;
         if (fdone === 1'b1) seq.push_back(trim);
         if (sdone === 1'b1) sd++;
      end
      checks++; if (seq.size() != 4) begin failures++; $display("FAIL cont_frames actual=%0d expected=4", seq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < seq.size()) ? seq[i] : 4'hx;
         exp_c = (i % 2 == 0) ? 4'd2 : 4'd3;
         checks++; if (got !== exp_c) begin failures++; $display("FAIL cont_code[%0d] actual=%0d expected=%0d", i, got, exp_c); end
      end
      n = 0;
      while (!hit && n < 20) begin
         @(negedge clk); n++;
         if (enclk === 1'b1) hit = 1'b1;
      end
      checks++; if (!hit) begin failures++; $display("FAIL cont_enclk_high actual=0 expected=1"); end
      stop = 1'b1;
      #1;
      checks++; if (fdone !== 1'b0 || sdone !== 1'b0) begin failures++; $display("FAIL stop_pulses actual=%b%b expected=00", fdone, sdone); end
      @(negedge clk);
      checks++; if (enclk !== 1'b0 || dout !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_outputs enclk_dout_busy actual=%b%b%b expected=000", enclk, dout, busy); end
      checks++; if (sd != 0 || sdone !== 1'b0) begin failures++; $display("FAIL stop_sdone actual=%0d expected=0", sd); end
      stop = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_stay_idle busy actual=%b expected=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] last;
      int         n, fd;
      n = 0; fd = 0; last = '0;
      cs = 4'd3; ce = 4'd5; cont = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (fdone !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++; if (fdone !== 1'b1) begin failures++; $display("FAIL rmid_first_frame actual=%b expected=1", fdone); end
      repeat (10) @(negedge clk);
      checks++; if (trim !== 4'd4) begin failures++; $display("FAIL rmid_frame2_trim actual=%0d expected=4", trim); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (enclk !== 1'b0 || dout !== 1'b0) begin failures++; $display("FAIL rmid_enclk_dout actual=%b%b expected=00", enclk, dout); end
      checks++; if (trim !== 4'd0 || trim_l !== 4'd0) begin failures++; $display("FAIL rmid_trim actual=%0d/%0d expected=0", trim, trim_l); end
      checks++; if (busy !== 1'b0 || busy_l !== 1'b0) begin failures++; $display("FAIL rmid_busy actual=%b%b expected=00", busy, busy_l); end
      checks++; if (fdone !== 1'b0 || sdone !== 1'b0) begin failures++; $display("FAIL rmid_pulses actual=%b%b expected=00", fdone, sdone); end
      rst = 1'b0; cs = 4'd7; ce = 4'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_first_start busy actual=%b expected=1", busy); end
      @(negedge clk); cs = 4'd0; ce = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         @(negedge clk); n++;
         if (fdone === 1'b1) begin fd++; last = trim; end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_end busy actual=%b expected=0", busy); end
      checks++; if (fd != 1 || last !== 4'd7) begin failures++; $display("FAIL rmid_single_frame actual fd=%0d code=%0d expected fd=1 code=7", fd, last); end
   endtask

   task automatic test_lsb();
      logic [4:0] pat[2];
      logic [3:0] codes[2];
      int         n;
      codes = '{4'd3, 4'd7};
      pat   = '{5'b00011, 5'b10111};
      for (int k = 0; k < 2; k++) begin
         cs = codes[k]; ce = codes[k]; cont = 1'b0; start = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int b = 0; b < FW; b++) begin
            @(negedge clk);
            checks++; if (dout_l !== pat[k][b]) begin failures++; $display("FAIL lsb_code%0d_bit%0d actual=%b expected=%b", codes[k], b, dout_l, pat[k][b]); end
            repeat (3) @(negedge clk);
         end
         n = 0;
         while (busy_l === 1'b1 && n < 30) begin @(negedge clk); n++; end
         checks++; if (busy_l !== 1'b0 || trim_l !== codes[k]) begin failures++; $display("FAIL lsb_end busy_trim actual=%b/%0d expected=0/%0d", busy_l, trim_l, codes[k]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sweep();
      test_wrap();
      test_cont_stop();
      test_reset_mid();
      test_lsb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
